ahb_mst_bridge: RTL and testbench



---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_mst_align_chk.sv | 21 ++
 rtl/ahb_mst_bridge.sv | 175 +++++++++++++++++
 tb/tb_ahb_mst_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the bus master, the SRAM slave and the decoder.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // Sizes wider than a word are not supported on a 32-bit bus; fold them to word.
   function automatic logic [2:0] norm_size(input logic [2:0] size);
      return (size > HSIZE_WORD) ? HSIZE_WORD : size;
   endfunction

endpackage

// File: rtl/ahb_mst_align_chk.sv
// Combinational misalignment detector for the AHB master bridge.
// Only instantiated when AHB_MST_ALIGN_CHECK_EN is defined.
module ahb_mst_align_chk
   import ahb_pkg::*;
(
   input  logic [1:0] addr_lo,
   input  logic [2:0] size,
   output logic       misaligned
);

   // Half-words need an even address, words need a 4-byte aligned address.
   always_comb begin
      misaligned = 1'b0;
      case (norm_size(size))
         HSIZE_HALF: misaligned = addr_lo[0];
         HSIZE_WORD: misaligned = |addr_lo;
         default:    misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/ahb_mst_bridge.sv
// AHB-Lite master bridge: turns the core's req/gnt/rvalid memory interface
// into pipelined SINGLE NONSEQ transfers. Address phase (AP) and data phase
// (DP) are separate registers so the next address overlaps the current data
// phase. A two-cycle ERROR response stalls re-issue of the pending AP for one
// cycle via err_st.
// Optional: define AHB_MST_ALIGN_CHECK_EN to reject misaligned requests
// locally (completed with an error, never put on the bus).
module ahb_mst_bridge
   import ahb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [2:0]    size_i,
   input  logic [DW-1:0] wdata_i,
   output logic          gnt_o,
   output logic          rvalid_o,
   output logic [DW-1:0] rdata_o,
   output logic          err_o,
   output logic [AW-1:0] haddr_o,
   output logic [1:0]    htrans_o,
   output logic          hwrite_o,
   output logic [2:0]    hsize_o,
   output logic [2:0]    hburst_o,
   output logic [DW-1:0] hwdata_o,
   input  logic [DW-1:0] hrdata_i,
   input  logic          hready_i,
   input  logic [1:0]    hresp_i
);

   // Address-phase register
   logic          ap_valid_q, ap_valid_d;
   logic [AW-1:0] ap_addr_q,  ap_addr_d;
   logic          ap_write_q, ap_write_d;
   logic [2:0]    ap_size_q,  ap_size_d;
   logic [DW-1:0] ap_wdata_q, ap_wdata_d;
   htrans_e       htrans_q,   htrans_d;

   // Data-phase register
   logic          dp_valid_q, dp_valid_d;
   logic          dp_write_q, dp_write_d;
   logic [DW-1:0] dp_wdata_q, dp_wdata_d;

   // Error stall flag and response outputs
   logic          err_st_q,   err_st_d;
   logic          rvalid_q,   rvalid_d;
   logic          err_q,      err_d;
   logic [DW-1:0] rdata_q,    rdata_d;

   logic          misaligned;
   logic          gnt;
   logic          accept;
   logic          ap_adv;
   logic          dp_done;
   logic          err_first;

`ifdef AHB_MST_ALIGN_CHECK_EN
   ahb_mst_align_chk u_align_chk (
      .addr_lo    (addr_i[1:0]),
      .size       (size_i),
      .misaligned (misaligned)
   );
`else
   assign misaligned = 1'b0;
`endif

   // Grant, pipeline advance and response generation for the next cycle.
   always_comb begin
      // A misaligned request only completes locally, so it waits for an empty pipe.
      gnt       = hresetn && !err_st_q && (!ap_valid_q || hready_i)
                  && (!misaligned || (!ap_valid_q && !dp_valid_q));
      accept    = req_i && gnt;
      ap_adv    = (htrans_q == HTRANS_NONSEQ) && hready_i;
      dp_done   = dp_valid_q && hready_i;
      err_first = dp_valid_q && !hready_i && (hresp_i == HRESP_ERROR);

      ap_valid_d = ap_valid_q;
      ap_addr_d  = ap_addr_q;
      ap_write_d = ap_write_q;
      ap_size_d  = ap_size_q;
      ap_wdata_d = ap_wdata_q;
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      dp_wdata_d = dp_wdata_q;
      err_st_d   = err_st_q;
      rdata_d    = rdata_q;

      if (accept && !misaligned) begin
         ap_valid_d = 1'b1;
         ap_addr_d  = addr_i;
         ap_write_d = we_i;
         ap_size_d  = norm_size(size_i);
         ap_wdata_d = wdata_i;
      end else if (ap_adv) begin
         ap_valid_d = 1'b0;
      end

      if (hready_i) begin
         dp_valid_d = ap_adv;
         if (ap_adv) begin
            dp_write_d = ap_write_q;
            dp_wdata_d = ap_wdata_q;
         end
      end

      // err_st suppresses NONSEQ for the second ERROR cycle, then the AP re-issues.
      if (err_first) begin
         err_st_d = 1'b1;
      end else if (err_st_q && hready_i) begin
         err_st_d = 1'b0;
      end

      htrans_d = (ap_valid_d && !err_st_d) ? HTRANS_NONSEQ : HTRANS_IDLE;

      rvalid_d = dp_done;
      err_d    = dp_done && (hresp_i == HRESP_ERROR);
      if (dp_done && !dp_write_q) begin
         rdata_d = hrdata_i;
      end
      if (accept && misaligned) begin
         rvalid_d = 1'b1;
         err_d    = 1'b1;
      end
   end

   // All pipeline and response state, cleared immediately on reset.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         ap_valid_q <= 1'b0;
         ap_addr_q  <= '0;
         ap_write_q <= 1'b0;
         ap_size_q  <= HSIZE_BYTE;
         ap_wdata_q <= '0;
         htrans_q   <= HTRANS_IDLE;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_wdata_q <= '0;
         err_st_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         ap_valid_q <= ap_valid_d;
         ap_addr_q  <= ap_addr_d;
         ap_write_q <= ap_write_d;
         ap_size_q  <= ap_size_d;
         ap_wdata_q <= ap_wdata_d;
         htrans_q   <= htrans_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_wdata_q <= dp_wdata_d;
         err_st_q   <= err_st_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign gnt_o    = gnt;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign haddr_o  = ap_addr_q;
   assign htrans_o = htrans_q;
   assign hwrite_o = ap_write_q;
   assign hsize_o  = ap_size_q;
   assign hburst_o = HBURST_SINGLE;
   assign hwdata_o = dp_wdata_q;

endmodule

// File: tb/tb_ahb_mst_bridge.sv
// Directed bench for ahb_mst_bridge. The slave side is driven cycle by cycle
// from the stimulus; expected values are written out by hand.
module tb_ahb_mst_bridge;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        req_i, we_i;
   logic [31:0] addr_i, wdata_i;
   logic [2:0]  size_i;
   logic        gnt_o, rvalid_o, err_o, hwrite_o;
   logic [31:0] rdata_o, haddr_o, hwdata_o, hrdata_i;
   logic [1:0]  htrans_o, hresp_i;
   logic [2:0]  hsize_o, hburst_o;
   logic        hready_i;

   int n_asserts = 0;
   int n_fail    = 0;

   ahb_mst_bridge #(.AW(32), .DW(32)) dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .req_i    (req_i),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .size_i   (size_i),
      .wdata_i  (wdata_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .haddr_o  (haddr_o),
      .htrans_o (htrans_o),
      .hwrite_o (hwrite_o),
      .hsize_o  (hsize_o),
      .hburst_o (hburst_o),
      .hwdata_o (hwdata_o),
      .hrdata_i (hrdata_i),
      .hready_i (hready_i),
      .hresp_i  (hresp_i)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic v, input logic we, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] wd);
      req_i = v; we_i = we; addr_i = a; size_i = sz; wdata_i = wd;
   endtask

   task automatic drive_slv(input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
      hready_i = rdy; hresp_i = resp; hrdata_i = rd;
   endtask

   // Advance to the next cycle; inputs are changed 1 time unit after the edge.
   task automatic nxt();
      @(posedge hclk);
      #1;
   endtask

   // Write then read the same address against a zero-wait slave.
   task automatic wr_rd(input logic [31:0] a, input logic [31:0] d);
      drive_req(1, 1, a, 3'd2, d); drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("wr_gnt", gnt_o, 1);
      nxt();
      drive_req(1, 0, a, 3'd2, 32'h0);
      @(negedge hclk);
      check("rd_gnt", gnt_o, 1);
      check("wr_htrans", htrans_o, 2'b10);
      check("wr_haddr", haddr_o, a);
      check("wr_hwrite", hwrite_o, 1);
      check("wr_hsize", hsize_o, 3'd2);
      check("hburst", hburst_o, 3'd0);
      nxt();
      drive_req(0, 0, 32'h0, 3'd0, 32'h0);
      @(negedge hclk);
      check("rd_htrans", htrans_o, 2'b10);
      check("rd_hwrite", hwrite_o, 0);
      check("wr_hwdata", hwdata_o, d);
      check("wr_no_rvalid_c2", rvalid_o, 0);
      nxt();
      drive_slv(1, 2'b00, d);
      @(negedge hclk);
      check("wr_rvalid", rvalid_o, 1);
      check("wr_err", err_o, 0);
      check("idle_after", htrans_o, 2'b00);
      nxt();
      drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("rd_rvalid", rvalid_o, 1);
      check("rd_err", err_o, 0);
      check("rd_rdata", rdata_o, d);
      nxt();
      @(negedge hclk);
      check("rvalid_single", rvalid_o, 0);
      nxt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, with a request pending to show gnt is held low.
      hresetn = 1'b0;
      drive_req(1, 1, 32'h4, 3'd2, 32'h1);
      drive_slv(1, 2'b00, 32'h0);
      nxt(); nxt();
      check("rst_gnt", gnt_o, 0);
      check("rst_htrans", htrans_o, 2'b00);
      check("rst_haddr", haddr_o, 0);
      check("rst_hwrite", hwrite_o, 0);
      check("rst_hsize", hsize_o, 0);
      check("rst_hwdata", hwdata_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_rvalid", rvalid_o, 0);
      check("rst_err", err_o, 0);
      drive_req(0, 0, 32'h0, 3'd0, 32'h0);
      hresetn = 1'b1;
      nxt();

      // Single write then read.
      wr_rd(32'h4, 32'hDEADBEEF);

      // Five back-to-back writes.
      for (int c = 0; c < 9; c++) begin
         if (c < 5) drive_req(1, 1, 32'(4 * c), 3'd2, 32'h1000 + 32'(c));
         else       drive_req(0, 0, 32'h0, 3'd0, 32'h0);
         @(negedge hclk);
         if (c < 5) check("b2b_gnt", gnt_o, 1);
         if (c >= 1 && c <= 5) begin
            check("b2b_htrans", htrans_o, 2'b10);
            check("b2b_haddr", haddr_o, 32'(4 * (c - 1)));
         end else begin
            check("b2b_idle", htrans_o, 2'b00);
         end
         if (c >= 2 && c <= 6) check("b2b_hwdata", hwdata_o, 32'h1000 + 32'(c - 2));
         check("b2b_rvalid", rvalid_o, (c >= 3 && c <= 7) ? 1'b1 : 1'b0);
         nxt();
      end

      // Wait states during a read data phase, second read waiting in AP.
      drive_req(1, 0, 32'h20, 3'd7, 32'h0); drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("ws_gnt0", gnt_o, 1);
      nxt();
      drive_req(1, 0, 32'h24, 3'd2, 32'h0);
      @(negedge hclk);
      check("ws_gnt1", gnt_o, 1);
      check("ws_haddr1", haddr_o, 32'h20);
      check("ws_size_fold", hsize_o, 3'd2);
      nxt();
      drive_req(0, 0, 32'h0, 3'd0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         drive_slv(0, 2'b00, 32'h0);
         @(negedge hclk);
         check("ws_haddr_hold", haddr_o, 32'h24);
         check("ws_htrans_hold", htrans_o, 2'b10);
         check("ws_gnt_low", gnt_o, 0);
         check("ws_no_rvalid", rvalid_o, 0);
         nxt();
      end
      drive_slv(1, 2'b00, 32'hA5A50020);
      @(negedge hclk);
      check("ws_gnt_back", gnt_o, 1);
      check("ws_no_rvalid_rdy", rvalid_o, 0);
      nxt();
      drive_slv(1, 2'b00, 32'h5A5A0024);
      @(negedge hclk);
      check("ws_rvalid_a", rvalid_o, 1);
      check("ws_rdata_a", rdata_o, 32'hA5A50020);
      check("ws_idle", htrans_o, 2'b00);
      nxt();
      drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("ws_rvalid_b", rvalid_o, 1);
      check("ws_rdata_b", rdata_o, 32'h5A5A0024);
      nxt();
      @(negedge hclk);
      check("ws_rvalid_end", rvalid_o, 0);
      nxt();

      // Two-cycle ERROR on read 0x8 with read 0xC pending in AP.
      drive_req(1, 0, 32'h8, 3'd2, 32'h0); drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("er_gnt0", gnt_o, 1);
      nxt();
      drive_req(1, 0, 32'hC, 3'd2, 32'h0);
      @(negedge hclk);
      check("er_gnt1", gnt_o, 1);
      nxt();
      drive_req(0, 0, 32'h0, 3'd0, 32'h0); drive_slv(0, 2'b01, 32'h0);
      @(negedge hclk);
      check("er1_htrans", htrans_o, 2'b10);
      check("er1_haddr", haddr_o, 32'hC);
      check("er1_gnt", gnt_o, 0);
      nxt();
      drive_slv(1, 2'b01, 32'h0);
      @(negedge hclk);
      check("er2_htrans_idle", htrans_o, 2'b00);
      check("er2_haddr", haddr_o, 32'hC);
      check("er2_gnt", gnt_o, 0);
      check("er2_no_rvalid", rvalid_o, 0);
      nxt();
      drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("er_rvalid", rvalid_o, 1);
      check("er_err", err_o, 1);
      check("er_reissue", htrans_o, 2'b10);
      check("er_reissue_addr", haddr_o, 32'hC);
      nxt();
      drive_slv(1, 2'b00, 32'h0000C0C0);
      @(negedge hclk);
      check("er_dp_idle", htrans_o, 2'b00);
      check("er_dp_no_rvalid", rvalid_o, 0);
      nxt();
      drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("er_c_rvalid", rvalid_o, 1);
      check("er_c_err", err_o, 0);
      check("er_c_rdata", rdata_o, 32'h0000C0C0);
      nxt();

      // Reset during a stalled write data phase.
      drive_req(1, 1, 32'h40, 3'd2, 32'h11112222); drive_slv(1, 2'b00, 32'h0);
      nxt();
      drive_req(0, 0, 32'h0, 3'd0, 32'h0);
      nxt();
      drive_slv(0, 2'b00, 32'h0);
      @(negedge hclk);
      check("mr_hwdata", hwdata_o, 32'h11112222);
      nxt();
      hresetn = 1'b0;
      #1;
      check("mr_htrans", htrans_o, 2'b00);
      check("mr_rvalid", rvalid_o, 0);
      check("mr_gnt", gnt_o, 0);
      check("mr_hwdata_clr", hwdata_o, 0);
      check("mr_haddr_clr", haddr_o, 0);
      nxt();
      hresetn = 1'b1;
      drive_slv(1, 2'b00, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge hclk);
         check("mr_no_resp", rvalid_o, 0);
         nxt();
      end
      wr_rd(32'h44, 32'h33334444);

`ifdef AHB_MST_ALIGN_CHECK_EN
      // Misaligned word read completes locally with an error.
      drive_req(1, 0, 32'h2, 3'd2, 32'h0); drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("al_gnt", gnt_o, 1);
      nxt();
      drive_req(0, 0, 32'h0, 3'd0, 32'h0);
      @(negedge hclk);
      check("al_no_nonseq", htrans_o, 2'b00);
      check("al_rvalid", rvalid_o, 1);
      check("al_err", err_o, 1);
      nxt();
      @(negedge hclk);
      check("al_rvalid_end", rvalid_o, 0);
      check("al_still_idle", htrans_o, 2'b00);
      nxt();
`else
      // Without the check, a misaligned word read goes straight to the slave.
      drive_req(1, 0, 32'h2, 3'd2, 32'h0); drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("na_gnt", gnt_o, 1);
      nxt();
      drive_req(0, 0, 32'h0, 3'd0, 32'h0);
      @(negedge hclk);
      check("na_htrans", htrans_o, 2'b10);
      check("na_haddr", haddr_o, 32'h2);
      nxt();
      drive_slv(1, 2'b00, 32'h0BADF00D);
      @(negedge hclk);
      check("na_dp_no_rvalid", rvalid_o, 0);
      nxt();
      drive_slv(1, 2'b00, 32'h0);
      @(negedge hclk);
      check("na_rvalid", rvalid_o, 1);
      check("na_err", err_o, 0);
      check("na_rdata", rdata_o, 32'h0BADF00D);
      nxt();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
